// File: rtl/wave_player.sv
// wave_player: ping-pong buffered playback stage behind the SDRAM sample FIFO.
// One bank fills from the FIFO while the other drains at a fixed sample rate.
// When the bank being played is empty, a silent sample and an underrun pulse
// are emitted instead.
module wave_player #(
   parameter int WAVE_SIZE  = 32,
   parameter int DATA_WIDTH = 16,
   parameter int SAMPLE_DIV = 6250
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   output logic                  o_fifo_rd,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_ef,
   input  logic                  i_fifo_done,
   output logic [DATA_WIDTH-1:0] o_sample,
   output logic                  o_sample_vld,
   output logic                  o_underrun,
   output logic [1:0]            o_level
);

   localparam int BANK_WORDS = 8 * WAVE_SIZE;
   localparam int AW         = $clog2(BANK_WORDS);
   localparam int CW         = AW + 1;
   localparam int RAM_DEPTH  = 2 ** (AW + 1);
   localparam logic [15:0]   DIV_LAST      = 16'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0] BANK_FULL_CNT = CW'(BANK_WORDS);

   typedef enum logic {F_IDLE, F_WAIT} fillState_e;

   // Fill side state
   fillState_e           fillState_q;
   logic                 fifoRd_q;
   logic                 fillBank_q;
   logic [CW-1:0]        wptr_q;
   logic [1:0][CW-1:0]   cnt_q;
   logic [1:0]           full_q;

   // Drain side state
   logic [15:0]          div_q;
   logic                 playBank_q;
   logic [AW-1:0]        rptr_q;
   logic                 rdPend_q;
   logic                 rdSilent_q;

   // Sample storage and output registers
   logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] ramRdata_q;
   logic [DATA_WIDTH-1:0] sample_q;
   logic                  sampleVld_q;
   logic                  underrun_q;
   logic [1:0]            level_q;

   // Combinational helpers
   logic          acceptWord;
   logic          fillDone;
   logic [CW-1:0] fillCount_d;
   logic [1:0]    fillSet;
   logic          tick;
   logic          playFull;
   logic [CW-1:0] playCnt;
   logic          lastWord;
   logic [1:0]    drainClr;
   logic [AW:0]   wrAddr;
   logic [AW:0]   rdAddr;

   // Decode word acceptance, bank completion and sample-tick events for this cycle
   always_comb begin
      acceptWord  = (fillState_q == F_WAIT) && i_fifo_ef && (wptr_q < BANK_FULL_CNT);
      fillDone    = (fillState_q == F_WAIT) && i_fifo_done;
      fillCount_d = wptr_q + CW'(acceptWord);
      fillSet     = '0;
      if (fillDone && (fillCount_d != '0)) begin
         fillSet[fillBank_q] = 1'b1;
      end
      wrAddr   = {fillBank_q, wptr_q[AW-1:0]};
      tick     = (div_q == DIV_LAST);
      playFull = full_q[playBank_q];
      playCnt  = cnt_q[playBank_q];
      lastWord = ({1'b0, rptr_q} == (playCnt - CW'(1)));
      drainClr = '0;
      if (tick && playFull && lastWord) begin
         drainClr[playBank_q] = 1'b1;
      end
      rdAddr = {playBank_q, rptr_q};
   end

   // Fill FSM: request one wave into the free bank, capture words, close the bank on done
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fillState_q <= F_IDLE;
         fifoRd_q    <= 1'b0;
         fillBank_q  <= 1'b0;
         wptr_q      <= '0;
         cnt_q       <= '0;
      end else begin
         case (fillState_q)
            F_IDLE: begin
               if (i_en && !full_q[fillBank_q]) begin
                  fillState_q <= F_WAIT;
                  fifoRd_q    <= 1'b1;
                  wptr_q      <= '0;
               end
            end
            F_WAIT: begin
               if (acceptWord) begin
                  wptr_q <= wptr_q + CW'(1);
               end
               if (i_fifo_done) begin
                  fillState_q        <= F_IDLE;
                  fifoRd_q           <= 1'b0;
                  cnt_q[fillBank_q]  <= fillCount_d;
                  fillBank_q         <= ~fillBank_q;
               end
            end
            default: begin
               fillState_q <= F_IDLE;
               fifoRd_q    <= 1'b0;
            end
         endcase
      end
   end

   // Bank full flags: fill marks its bank, drain releases the other one
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         full_q <= '0;
      end else begin
         full_q <= (full_q | fillSet) & ~drainClr;
      end
   end

   // Sample-rate divider and play pointer walking through the full bank
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q      <= '0;
         playBank_q <= 1'b0;
         rptr_q     <= '0;
         rdPend_q   <= 1'b0;
         rdSilent_q <= 1'b0;
      end else begin
         if (!i_en || tick) begin
            div_q <= '0;
         end else begin
            div_q <= div_q + 16'd1;
         end
         if (tick && playFull) begin
            if (lastWord) begin
               rptr_q     <= '0;
               playBank_q <= ~playBank_q;
            end else begin
               rptr_q <= rptr_q + AW'(1);
            end
         end
         rdPend_q   <= tick;
         rdSilent_q <= !playFull;
      end
   end

   // Sample RAM write port, driven by the fill side
   always_ff @(posedge i_clk) begin
      if (acceptWord) begin
         mem_q[wrAddr] <= i_fifo_data;
      end
   end

   // Sample RAM synchronous read port, driven by the drain side
   always_ff @(posedge i_clk) begin
      if (tick && playFull) begin
         ramRdata_q <= mem_q[rdAddr];
      end
   end

   // Output stage: present the fetched sample (or silence) and the buffer level
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sample_q    <= '0;
         sampleVld_q <= 1'b0;
         underrun_q  <= 1'b0;
         level_q     <= '0;
      end else begin
         sampleVld_q <= rdPend_q;
         underrun_q  <= rdPend_q && rdSilent_q;
         if (rdPend_q) begin
            sample_q <= rdSilent_q ? '0 : ramRdata_q;
         end
         level_q <= {1'b0, full_q[0]} + {1'b0, full_q[1]};
      end
   end

   assign o_fifo_rd    = fifoRd_q;
   assign o_sample     = sample_q;
   assign o_sample_vld = sampleVld_q;
   assign o_underrun   = underrun_q;
   assign o_level      = level_q;

endmodule

// File: doc/wave_player.md
# wave_player

Playback stage directly downstream of the SDRAM sample FIFO. It requests one wave (WAVE_SIZE bursts of 8 words) at a time, captures the returned words into a two-bank ping-pong buffer, and releases them to the audio output at a fixed sample rate. When no sample is buffered, it emits silence and flags an underrun.

## Interface
- WAVE_SIZE, 32, bursts per wave; bank depth is BANK_WORDS = 8*WAVE_SIZE (default 256 words)
- DATA_WIDTH, 16, sample width
- SAMPLE_DIV, 6250, i_clk cycles per output sample (100 MHz / 16 kHz); legal range 4..65535

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  playback enable (level)
- o_fifo_rd  out  1  wave read request to FIFO (level)
- i_fifo_data  in  DATA_WIDTH  read word from FIFO
- i_fifo_ef  in  1  i_fifo_data valid this cycle
- i_fifo_done  in  1  one-cycle pulse: requested wave complete
- o_sample  out  DATA_WIDTH  output sample
- o_sample_vld  out  1  one-cycle strobe per sample period
- o_underrun  out  1  one-cycle pulse: silence emitted for lack of data
- o_level  out  2  number of full banks (0..2)

## Operation
- Storage: RAM of 2*BANK_WORDS words with synchronous read. Address = {bank, word index}.
- Per-bank state: full[b] and cnt[b] (number of valid words, 0..BANK_WORDS). o_level = full[0]+full[1].
- Fill FSM, states F_IDLE, F_WAIT:
  - F_IDLE -> F_WAIT when i_en=1 and full[fill_bank]=0. Entry clears wptr.
  - F_WAIT holds o_fifo_rd=1. Each i_fifo_ef writes i_fifo_data to {fill_bank, wptr}, then wptr increments. When wptr=BANK_WORDS, further words are dropped and wptr saturates.
  - F_WAIT -> F_IDLE on i_fifo_done. That cycle sets full[fill_bank]=1 and cnt[fill_bank]=wptr (plus 1 if i_fifo_ef is also high that cycle and the word is accepted), and toggles fill_bank. If the resulting count is 0, the bank is not marked full, but fill_bank still toggles.
  - i_en falling while in F_WAIT does not abort; the request completes on i_fifo_done.
  - o_fifo_rd = (state==F_WAIT), registered.
- Drain:
  - 16-bit divider counts 0..SAMPLE_DIV-1 while i_en=1; it is held at 0 while i_en=0.
  - tick = (div==SAMPLE_DIV-1).
  - On tick with full[play_bank]=1: read {play_bank, rptr}, then rptr+1. When rptr=cnt[play_bank]-1: clear full[play_bank], rptr<=0, toggle play_bank.
  - On tick with full[play_bank]=0: o_sample<=0 and o_underrun pulses.
- Fill sets and drain clears always target different banks; both in the same cycle are legal and independent.

## Timing
- Reset values: o_fifo_rd=0, o_sample=0, o_sample_vld=0, o_underrun=0, o_level=0. Also cleared by reset: full=0, fill_bank=0, play_bank=0, wptr=0, rptr=0, div=0, FSM=F_IDLE.
- Reset mid-wave discards all buffered data. No request is in flight after reset.
- o_fifo_rd rises 1 cycle after the F_IDLE->F_WAIT decision. It falls the cycle after i_fifo_done.
- Sample latency: tick at cycle T -> RAM read at T -> o_sample and o_sample_vld registered at T+2. o_underrun also asserts at T+2. o_sample holds its value between strobes.
- o_sample_vld pulses once per SAMPLE_DIV cycles while i_en=1, including silent samples.
- A bank marked full at cycle T can be played by a tick at T+1 or later.
- o_level updates 1 cycle after the full[] change.

## Test plan
- Basic flow: i_en=1, SAMPLE_DIV=4, FIFO model returns 256 words 0..255 then i_fifo_done. Required: o_sample_vld every 4 cycles; o_sample sequence 0,1,2,…; a second request opens while bank 0 plays; no underrun once bank 1 fills in time.
- Startup underrun: i_en=1 with FIFO idle for 20 cycles. Required: 5 strobes with o_sample=0, each with o_underrun=1.
- Short wave: i_fifo_done after 10 words (0x100..0x109). Required: exactly 10 samples played, then play_bank toggles; next bank plays or underrun follows.
- Overlong wave: 260 words before done. Required: words 256..259 are dropped; cnt=256.
- Backpressure: drain disabled by tick starvation (SAMPLE_DIV=65535), two waves delivered. Required: o_level=2, o_fifo_rd stays 0 until the first bank empties.
- Reset mid-F_WAIT after 100 words. Required: all outputs 0 immediately; o_level=0; the next wave starts in bank 0 at wptr=0.
